rsa_op_arbiter: RTL
===================

RSA_OP_ARBITER -- requirements
Module: rsa_op_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, maximum BUSY cycles before abort; legal range 2..65535.
REQ-002 Parameter CNT_W, default 16, watchdog counter width; CNT_W SHALL be wide enough to hold TIMEOUT_CYCLES.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 enc_req  input  1  level request for one RSA encryption, from the encrypt requester.
REQ-006 dec_req  input  1  level request for one RSA decryption, from the decrypt requester.
REQ-007 core_done  input  1  one-cycle completion pulse from the RSA core.
REQ-008 E_D  output  2  core mode: 2'b10 encrypt, 2'b01 decrypt, 2'b00 idle.
REQ-009 core_start  output  1  one-cycle start pulse to the RSA core.
REQ-010 enc_grant / dec_grant  output  1 each  high for the whole operation owned by that requester.
REQ-011 enc_done / dec_done  output  1 each  one-cycle completion pulse to the owning requester.
REQ-012 err_timeout  output  1  one-cycle pulse when an operation is aborted by the watchdog.

Function
REQ-013 FSM states SHALL be IDLE, START, BUSY, DONE, ABORT; all outputs SHALL be registered.
REQ-014 IDLE: if enc_req or dec_req is high at a clock edge, the FSM SHALL go to START and latch the winner; otherwise it stays in IDLE.
REQ-015 Single request: that request SHALL win; both requests high: the requester not served last SHALL win (round-robin).
REQ-016 The last-served pointer SHALL update only on DONE or ABORT.
REQ-017 START (one cycle): core_start=1; E_D = winner encoding; winner grant=1; the next state SHALL be BUSY.
REQ-018 E_D and grant SHALL hold constant from START through the final DONE/ABORT cycle, whatever the request inputs do.
REQ-019 Latency: request sampled in cycle 0 gives core_start, E_D and grant in cycle 1.
REQ-020 BUSY: the watchdog counter SHALL clear on BUSY entry and increment each BUSY cycle.
REQ-021 core_done SHALL be sampled only in BUSY; a pulse in any other state SHALL be ignored.
REQ-022 core_done high in BUSY SHALL cause DONE in the next cycle.
REQ-023 If the counter reaches TIMEOUT_CYCLES-1 with core_done low, the next state SHALL be ABORT.
REQ-024 core_done and timeout in the same cycle: core_done SHALL win and go to DONE.
REQ-025 DONE (one cycle): pulse the owner's enc_done or dec_done; grant and E_D stay held; the next state SHALL be IDLE.
REQ-026 ABORT (one cycle): err_timeout=1; no done pulse; the next state SHALL be IDLE.
REQ-027 On return to IDLE, E_D=2'b00 and both grants are 0; a still-asserted request SHALL be re-arbitrated in that IDLE cycle.
REQ-028 Back-to-back operations: a new operation SHALL take a minimum of 3 cycles of overhead plus core time (IDLE, START, DONE).
REQ-029 E_D SHALL never be 2'b11, and at most one grant SHALL be high at any time.

Reset
REQ-030 On rst high, at the next edge: state=IDLE; E_D=2'b00; core_start, grants, done pulses and err_timeout = 0; counter = 0.
REQ-031 On the same reset, the last-served pointer SHALL be set to decrypt, so encrypt wins the first tie.
REQ-032 Reset mid-operation SHALL abort silently, with no done and no err pulse.
REQ-033 Reset SHALL take priority over every other input in the same cycle.

Structure
REQ-034 Shared package rsa_ctrl_pkg SHALL hold the FSM state enum and the constants ED_IDLE=2'b00, ED_DEC=2'b01, ED_ENC=2'b10.
REQ-035 The watchdog SHALL be one sub-module, rsa_watchdog, with ports clk, rst, clr, en, expired, parameterised by TIMEOUT_CYCLES; arbitration and FSM stay in the top.

Verification
REQ-036 enc_req=1 at cycle 0, core_done at cycle 5 -> core_start and E_D=10 at cycle 1; enc_done at cycle 6; E_D=00 at cycle 7.
REQ-037 After reset, both requests held high, core_done 3 cycles after each start -> grants alternate enc, dec, enc, dec; E_D alternates 10, 01.
REQ-038 TIMEOUT_CYCLES=8, dec_req=1, no core_done -> err_timeout at cycle 10; no dec_done; E_D=00 at cycle 11.
REQ-039 core_done coinciding with the last timeout cycle -> done pulse, no err_timeout; a stray core_done in IDLE or START -> no effect.
REQ-040 rst asserted in BUSY with enc granted -> next cycle all outputs zero; no done or err pulse; a following tie is granted to encrypt.

Source files
------------

// File: rtl/rsa_ctrl_pkg.sv
// Shared types and constants for the RSA operation arbiter.
package rsa_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BUSY  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ABORT = 3'd4
    } state_t;

    localparam logic [1:0] ED_IDLE = 2'b00;
    localparam logic [1:0] ED_DEC  = 2'b01;
    localparam logic [1:0] ED_ENC  = 2'b10;

endpackage

// File: rtl/rsa_watchdog.sv
// BUSY-cycle watchdog: cleared before each operation, counts while enabled,
// flags the cycle in which the count reaches TIMEOUT_CYCLES-1.
module rsa_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == LAST_COUNT);

endmodule

// File: rtl/rsa_op_arbiter.sv
// Round-robin arbiter sharing one RSA core between an encrypt and a decrypt
// requester, with a watchdog that aborts operations the core never finishes.
module rsa_op_arbiter
    import rsa_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enc_req,
    input  logic       dec_req,
    input  logic       core_done,
    output logic [1:0] E_D,
    output logic       core_start,
    output logic       enc_grant,
    output logic       dec_grant,
    output logic       enc_done,
    output logic       dec_done,
    output logic       err_timeout
);

    state_t     state, state_next;
    logic       owner_dec, owner_next;
    logic       last_dec, last_next;
    logic       wd_clr, wd_en, wd_expired;
    logic       active_next;
    logic [1:0] e_d_next;

    rsa_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expired(wd_expired)
    );

    // Next state, arbitration and watchdog control
    always_comb begin
        state_next = state;
        owner_next = owner_dec;
        last_next  = last_dec;
        wd_clr     = 1'b0;
        wd_en      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enc_req || dec_req) begin
                    state_next = ST_START;
                    // on a tie the side not served last wins
                    owner_next = dec_req && !(enc_req && last_dec);
                end
            end
            ST_START: begin
                state_next = ST_BUSY;
                wd_clr     = 1'b1;
            end
            ST_BUSY: begin
                wd_en = 1'b1;
                if (core_done) begin
                    state_next = ST_DONE;
                end else if (wd_expired) begin
                    state_next = ST_ABORT;
                end
            end
            ST_DONE, ST_ABORT: begin
                state_next = ST_IDLE;
                last_next  = owner_dec;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it
    always_comb begin
        active_next = (state_next != ST_IDLE);
        e_d_next    = ED_IDLE;
        if (active_next) begin
            e_d_next = owner_next ? ED_DEC : ED_ENC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            owner_dec   <= 1'b0;
            last_dec    <= 1'b1;
            E_D         <= ED_IDLE;
            core_start  <= 1'b0;
            enc_grant   <= 1'b0;
            dec_grant   <= 1'b0;
            enc_done    <= 1'b0;
            dec_done    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_next;
            owner_dec   <= owner_next;
            last_dec    <= last_next;
            E_D         <= e_d_next;
            core_start  <= (state_next == ST_START);
            enc_grant   <= active_next && !owner_next;
            dec_grant   <= active_next && owner_next;
            enc_done    <= (state_next == ST_DONE) && !owner_next;
            dec_done    <= (state_next == ST_DONE) && owner_next;
            err_timeout <= (state_next == ST_ABORT);
        end
    end

endmodule
